// File: rtl/piso_reader.sv
// Parallel-in/serial-out reader: loads a WIDTH-bit word, shifts it out one bit per cycle
// in a selectable bit order, then idles GAP cycles. Define PISO_READER_PARITY_EN to append even parity.
module piso_reader #(
  parameter int WIDTH = 16,
  parameter int GAP   = 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             msb_first,
  input  logic             flush,
  output logic             q,
  output logic             q_valid,
  output logic             q_last
);

`ifdef PISO_READER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int                CNT_W   = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0]  FRAME_C = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [3:0]        GAP_C   = 4'(GAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             msb_q, msb_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [3:0]       gapcnt_q, gapcnt_d;
  logic             q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             q_last_q, q_last_d;
`ifdef PISO_READER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign ld_ready = (state_q == IDLE) && !rst;
  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign q_last   = q_last_q;

  // bitcnt_q holds the number of frame bits still to present, including the current one.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    msb_d    = msb_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
`ifdef PISO_READER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (ld_valid && ld_ready && !flush) begin
          state_d  = SHIFT;
          shreg_d  = ld_data;
          msb_d    = msb_first;
          bitcnt_d = FRAME_C;
`ifdef PISO_READER_PARITY_EN
          parity_d = ^ld_data;
`endif
        end
      end
      SHIFT: begin
        if (flush) begin
          state_d  = IDLE;
          shreg_d  = '0;
          bitcnt_d = '0;
        end else if (bitcnt_q == CNT_ONE) begin
          shreg_d  = '0;
          bitcnt_d = '0;
          if (GAP > 0) begin
            state_d  = GAPW;
            gapcnt_d = GAP_C;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          bitcnt_d = bitcnt_q - CNT_ONE;
          shreg_d  = msb_q ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        end
      end
      GAPW: begin
        if (flush || (gapcnt_q <= 4'd1)) begin
          state_d  = IDLE;
          gapcnt_d = '0;
        end else begin
          gapcnt_d = gapcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so the first bit appears one cycle after load.
  always_comb begin
    q_valid_d = (state_d == SHIFT);
    q_last_d  = q_valid_d && (bitcnt_d == CNT_ONE);
    q_d       = 1'b0;
    if (q_valid_d) begin
      q_d = msb_d ? shreg_d[WIDTH-1] : shreg_d[0];
`ifdef PISO_READER_PARITY_EN
      if (bitcnt_d == CNT_ONE) begin
        q_d = parity_d;
      end
`endif
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      msb_q     <= 1'b0;
      bitcnt_q  <= '0;
      gapcnt_q  <= '0;
      q_q       <= 1'b0;
      q_valid_q <= 1'b0;
      q_last_q  <= 1'b0;
`ifdef PISO_READER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      msb_q     <= msb_d;
      bitcnt_q  <= bitcnt_d;
      gapcnt_q  <= gapcnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_last_q  <= q_last_d;
`ifdef PISO_READER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_reader.sv
// Self-checking bench for piso_reader: one instance with GAP=1, one with GAP=0 for back-to-back loads.
// Expected bit streams come from a word-level model of the frame format.
module tb_piso_reader;
  localparam int WIDTH = 16;
  localparam int GAP   = 1;
`ifdef PISO_READER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic ck = 1'b0;
  logic rst = 1'b1;
  logic ld_valid = 1'b0;
  logic [WIDTH-1:0] ld_data = '0;
  logic msb_first = 1'b0;
  logic flush = 1'b0;
  logic ld_ready, q, q_valid, q_last;

  logic ld_valid0 = 1'b0;
  logic [WIDTH-1:0] ld_data0 = '0;
  logic ld_ready0, q0, q_valid0, q_last0;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];
  logic exp2_q[$];

  always #5 ck = ~ck;

  piso_reader #(.WIDTH(WIDTH), .GAP(GAP)) dut (
    .ck(ck), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .msb_first(msb_first), .flush(flush), .q(q), .q_valid(q_valid), .q_last(q_last)
  );

  piso_reader #(.WIDTH(WIDTH), .GAP(0)) dut0 (
    .ck(ck), .rst(rst), .ld_valid(ld_valid0), .ld_ready(ld_ready0), .ld_data(ld_data0),
    .msb_first(msb_first), .flush(flush), .q(q0), .q_valid(q_valid0), .q_last(q_last0)
  );

  // Frame model: data bits in the requested order, then optional even parity.
  function automatic void build_exp(input logic [WIDTH-1:0] w, input logic msb);
    exp_q.delete();
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(msb ? w[WIDTH-1-i] : w[i]);
`ifdef PISO_READER_PARITY_EN
    exp_q.push_back(^w);
`endif
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!ld_ready && k < 100) begin
      @(negedge ck);
      k++;
    end
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready: ld_ready=%b required 1 within 100 cycles", ld_ready);
    end
  endtask

  // Loads one word, checks every frame bit, the gap, and the return of ld_ready.
  task automatic run_frame(input string tag, input logic [WIDTH-1:0] w, input logic msb);
    wait_ready();
    ld_data = w; msb_first = msb; ld_valid = 1'b1;
    @(negedge ck);
    ld_valid = 1'b0; ld_data = WIDTH'($urandom);
    for (int i = 0; i < FRAME; i++) begin
      n_checks++;
      if (q_valid !== 1'b1) begin n_fail++; $display("FAIL %s q_valid bit%0d: got %b want 1", tag, i, q_valid); end
      n_checks++;
      if (q !== exp_q[i]) begin n_fail++; $display("FAIL %s q bit%0d: got %b want %b", tag, i, q, exp_q[i]); end
      n_checks++;
      if (q_last !== (i == FRAME - 1)) begin n_fail++; $display("FAIL %s q_last bit%0d: got %b want %b", tag, i, q_last, (i == FRAME - 1)); end
      n_checks++;
      if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL %s ld_ready bit%0d: got %b want 0", tag, i, ld_ready); end
      @(negedge ck);
    end
    for (int g = 0; g < GAP; g++) begin
      n_checks++;
      if ({q_valid, q, q_last, ld_ready} !== 4'b0000) begin
        n_fail++; $display("FAIL %s gap%0d: valid/q/last/ready=%b want 0000", tag, g, {q_valid, q, q_last, ld_ready});
      end
      @(negedge ck);
    end
    n_checks++;
    if ({ld_ready, q_valid} !== 2'b10) begin n_fail++; $display("FAIL %s after_gap: ready/valid=%b want 10", tag, {ld_ready, q_valid}); end
    $display("%s word=%h msb_first=%0d frame=%0d", tag, w, msb, FRAME);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge ck);
    n_checks++;
    if ({ld_ready, q_valid, q, q_last} !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs: got %b want 0000", {ld_ready, q_valid, q, q_last}); end
    n_checks++;
    if ({ld_ready0, q_valid0, q0, q_last0} !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs0: got %b want 0000", {ld_ready0, q_valid0, q0, q_last0}); end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ld_ready, ld_ready0} !== 2'b11) begin n_fail++; $display("FAIL reset_release_ready: got %b want 11", {ld_ready, ld_ready0}); end
    $display("reset released");
    @(negedge ck);
  endtask

  task automatic test_directed();
    logic [15:0] msb_seq = 16'b1010_0101_1100_0011;
    logic [15:0] lsb_seq = 16'b1100_0011_1010_0101;
    exp_q.delete();
    for (int i = 15; i >= 0; i--) exp_q.push_back(msb_seq[i]);
`ifdef PISO_READER_PARITY_EN
    exp_q.push_back(1'b0);
`endif
    run_frame("directed_msb", 16'hA5C3, 1'b1);
    exp_q.delete();
    for (int i = 15; i >= 0; i--) exp_q.push_back(lsb_seq[i]);
`ifdef PISO_READER_PARITY_EN
    exp_q.push_back(1'b0);
`endif
    run_frame("directed_lsb", 16'hA5C3, 1'b0);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] w;
    logic m;
    for (int n = 0; n < 12; n++) begin
      w = WIDTH'($urandom);
      m = 1'($urandom_range(0, 1));
      build_exp(w, m);
      run_frame("random", w, m);
    end
  endtask

  task automatic test_parity();
`ifdef PISO_READER_PARITY_EN
    build_exp(16'h0007, 1'b1);
    n_checks++;
    if (exp_q[FRAME-1] !== 1'b1) begin n_fail++; $display("FAIL parity_model: got %b want 1", exp_q[FRAME-1]); end
    run_frame("parity", 16'h0007, 1'b1);
`else
    $display("parity feature not built");
`endif
  endtask

  task automatic test_back_to_back();
    msb_first = 1'b1;
    build_exp(16'h0001, 1'b1);
    exp2_q = exp_q;
    build_exp(16'h8000, 1'b1);
    n_checks++;
    if (ld_ready0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", ld_ready0); end
    ld_data0 = 16'h0001; ld_valid0 = 1'b1;
    @(negedge ck);
    ld_data0 = 16'h8000;
    for (int i = 0; i < FRAME; i++) begin
      n_checks++;
      if ({q_valid0, q0, q_last0} !== {1'b1, exp2_q[i], 1'(i == FRAME - 1)}) begin
        n_fail++; $display("FAIL b2b_first bit%0d: valid/q/last=%b want %b", i, {q_valid0, q0, q_last0}, {1'b1, exp2_q[i], 1'(i == FRAME - 1)});
      end
      @(negedge ck);
    end
    n_checks++;
    if ({q_valid0, ld_ready0} !== 2'b01) begin n_fail++; $display("FAIL b2b_gap: valid/ready=%b want 01", {q_valid0, ld_ready0}); end
    @(negedge ck);
    ld_valid0 = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      n_checks++;
      if ({q_valid0, q0, q_last0} !== {1'b1, exp_q[i], 1'(i == FRAME - 1)}) begin
        n_fail++; $display("FAIL b2b_second bit%0d: valid/q/last=%b want %b", i, {q_valid0, q0, q_last0}, {1'b1, exp_q[i], 1'(i == FRAME - 1)});
      end
      @(negedge ck);
    end
    n_checks++;
    if ({q_valid0, ld_ready0} !== 2'b01) begin n_fail++; $display("FAIL b2b_end: valid/ready=%b want 01", {q_valid0, ld_ready0}); end
    $display("back_to_back words=0001,8000 period=%0d", FRAME + 1);
  endtask

  task automatic test_flush();
    logic [WIDTH-1:0] w = WIDTH'($urandom);
    build_exp(w, 1'b1);
    wait_ready();
    ld_data = w; msb_first = 1'b1; ld_valid = 1'b1;
    @(negedge ck);
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({q_valid, q} !== {1'b1, exp_q[i]}) begin n_fail++; $display("FAIL flush_pre bit%0d: valid/q=%b want %b", i, {q_valid, q}, {1'b1, exp_q[i]}); end
      @(negedge ck);
    end
    n_checks++;
    if ({q_valid, q} !== {1'b1, exp_q[4]}) begin n_fail++; $display("FAIL flush_bit5: valid/q=%b want %b", {q_valid, q}, {1'b1, exp_q[4]}); end
    flush = 1'b1;
    @(negedge ck);
    flush = 1'b0;
    n_checks++;
    if ({q_valid, q, q_last, ld_ready} !== 4'b0001) begin n_fail++; $display("FAIL flush_after: valid/q/last/ready=%b want 0001", {q_valid, q, q_last, ld_ready}); end
    for (int i = 0; i < FRAME; i++) begin
      n_checks++;
      if ({q_valid, q_last} !== 2'b00) begin n_fail++; $display("FAIL flush_quiet cyc%0d: valid/last=%b want 00", i, {q_valid, q_last}); end
      @(negedge ck);
    end
    $display("flush word=%h at shift cycle 5", w);
    ld_valid = 1'b1; flush = 1'b1; ld_data = WIDTH'($urandom);
    @(negedge ck);
    ld_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if ({q_valid, ld_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_vs_load: valid/ready=%b want 01", {q_valid, ld_ready}); end
    @(negedge ck);
    n_checks++;
    if (q_valid !== 1'b0) begin n_fail++; $display("FAIL flush_vs_load_late: valid=%b want 0", q_valid); end
    $display("flush with ld_valid in idle");
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] w  = WIDTH'($urandom);
    logic [WIDTH-1:0] w2 = WIDTH'($urandom);
    wait_ready();
    ld_data = w; msb_first = 1'b0; ld_valid = 1'b1;
    @(negedge ck);
    ld_valid = 1'b0;
    repeat (5) @(negedge ck);
    build_exp(w2, 1'b1);
    rst = 1'b1; ld_valid = 1'b1; ld_data = w2; msb_first = 1'b1;
    #1;
    n_checks++;
    if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 0", ld_ready); end
    @(negedge ck);
    n_checks++;
    if ({q_valid, q, q_last, ld_ready} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_outputs: valid/q/last/ready=%b want 0000", {q_valid, q, q_last, ld_ready}); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", ld_ready); end
    @(negedge ck);
    ld_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      n_checks++;
      if ({q_valid, q, q_last} !== {1'b1, exp_q[i], 1'(i == FRAME - 1)}) begin
        n_fail++; $display("FAIL rst_reload bit%0d: valid/q/last=%b want %b", i, {q_valid, q, q_last}, {1'b1, exp_q[i], 1'(i == FRAME - 1)});
      end
      @(negedge ck);
    end
    $display("reset mid-word, reload word=%h", w2);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_parity();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    repeat (4) @(negedge ck);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
